ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_sync_edge.sv | 39 +++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks.
//   ps2_tx_state_t  : host transmitter FSM states
//   PS2_EDGE_*      : device clock falling-edge numbers within a host->device frame
//   odd_parity()    : parity bit that makes the 9-bit {parity,data} word odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    BITS      = 3'd3,
    WAIT_IDLE = 3'd4,
    FIN       = 3'd5
  } ps2_tx_state_t;

  localparam logic [3:0] PS2_DATA_BITS   = 4'd8;
  localparam logic [3:0] PS2_EDGE_PARITY = 4'd9;
  localparam logic [3:0] PS2_EDGE_STOP   = 4'd10;
  localparam logic [3:0] PS2_EDGE_ACK    = 4'd11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines plus a
// falling-edge pulse on the synchronized clock.
//   clk, rst          : system clock, synchronous active-low reset
//   ps2_clk_in        : raw (asynchronous) PS/2 clock line
//   ps2_d_in          : raw (asynchronous) PS/2 data line
//   clk_sync, d_sync  : synchronized line levels
//   clk_fall          : one-cycle pulse, previous synced clock 1 and current 0
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_d_in,
  output logic clk_sync,
  output logic d_sync,
  output logic clk_fall
);

  logic [1:0] clk_meta_r;
  logic [1:0] d_meta_r;
  logic       clk_prev_r;

  // Synchronizer chains; reset to the idle-high line level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_meta_r <= 2'b11;
      d_meta_r   <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_meta_r <= {clk_meta_r[0], ps2_clk_in};
      d_meta_r   <= {d_meta_r[0], ps2_d_in};
      clk_prev_r <= clk_meta_r[1];
    end
  end

  assign clk_sync = clk_meta_r[1];
  assign d_sync   = d_meta_r[1];
  assign clk_fall = clk_prev_r & ~clk_meta_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device.
//   clk, rst        : system clock, synchronous active-low reset
//   tx_data         : command byte, captured when tx_start is accepted
//   tx_start        : one-cycle request, accepted only while busy=0
//   busy            : cycle after acceptance through the done cycle
//   done, err       : end-of-transfer pulse; err=1 for NACK or timeout
//   rx_mask         : copy of busy, tells the receiver to ignore traffic
//   ps2_clk_in/d_in : raw PS/2 lines
//   ps2_clk_oe/d_oe : 1 = pull the corresponding line low (open drain)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rx_mask,
  input  logic       ps2_clk_in,
  input  logic       ps2_d_in,
  output logic       ps2_clk_oe,
  output logic       ps2_d_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_sync_s;
  logic d_sync_s;
  logic clk_fall_s;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_d_in   (ps2_d_in),
    .clk_sync   (clk_sync_s),
    .d_sync     (d_sync_s),
    .clk_fall   (clk_fall_s)
  );

  ps2_tx_state_t    state_r, state_nx;
  logic [INH_W-1:0] inh_cnt_r, inh_cnt_nx;
  logic [TO_W-1:0]  to_cnt_r, to_cnt_nx;
  logic [3:0]       edge_cnt_r, edge_cnt_nx;
  logic [3:0]       edge_next_s;
  logic [7:0]       sh_r, sh_nx;
  logic             par_r, par_nx;
  logic             err_flag_r, err_flag_nx;
  logic             d_bit_nx;
  logic             busy_r, done_r, err_r, clk_oe_r, d_oe_r;

  // Next-state, counters and the data-line value to drive in BITS.
  always_comb begin
    state_nx    = state_r;
    inh_cnt_nx  = inh_cnt_r;
    to_cnt_nx   = to_cnt_r;
    edge_cnt_nx = edge_cnt_r;
    sh_nx       = sh_r;
    par_nx      = par_r;
    err_flag_nx = err_flag_r;
    d_bit_nx    = d_oe_r;
    edge_next_s = edge_cnt_r + 4'd1;

    case (state_r)
      IDLE: begin
        d_bit_nx = 1'b0;
        if (tx_start) begin
          state_nx    = INHIBIT;
          sh_nx       = tx_data;
          par_nx      = odd_parity(tx_data);
          inh_cnt_nx  = '0;
          err_flag_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end

      INHIBIT: begin
        if (inh_cnt_r == INH_LAST) begin
          state_nx = REQ;
        end else begin
          inh_cnt_nx = inh_cnt_r + 1'b1;
        end
      end

      REQ: begin
        state_nx    = BITS;
        to_cnt_nx   = '0;
        edge_cnt_nx = 4'd0;
      end

      BITS: begin
        // A device edge takes priority over an expiring timeout in the same cycle.
        if (clk_fall_s) begin
          to_cnt_nx   = '0;
          edge_cnt_nx = edge_next_s;
          if (edge_next_s <= PS2_DATA_BITS) begin
            // edge 8 wraps [2:0] to 0, so minus one selects bit 7
            d_bit_nx = ~sh_r[edge_next_s[2:0] - 3'd1];
          end else if (edge_next_s == PS2_EDGE_PARITY) begin
            d_bit_nx = ~par_r;
          end else if (edge_next_s == PS2_EDGE_STOP) begin
            d_bit_nx = 1'b0;
          end else begin
            // PS2_EDGE_ACK: device pulls data low to acknowledge
            d_bit_nx    = 1'b0;
            err_flag_nx = d_sync_s;
            state_nx    = WAIT_IDLE;
          end
        end else if (to_cnt_r == TO_LAST) begin
          state_nx    = FIN;
          err_flag_nx = 1'b1;
          d_bit_nx    = 1'b0;
        end else begin
          to_cnt_nx = to_cnt_r + 1'b1;
        end
      end

      WAIT_IDLE: begin
        d_bit_nx = 1'b0;
        if (clk_sync_s && d_sync_s) begin
          state_nx = FIN;
        end else if (clk_fall_s) begin
          to_cnt_nx = '0;
        end else if (to_cnt_r == TO_LAST) begin
          state_nx    = FIN;
          err_flag_nx = 1'b1;
        end else begin
          to_cnt_nx = to_cnt_r + 1'b1;
        end
      end

      FIN: begin
        d_bit_nx = 1'b0;
        state_nx = IDLE;
      end

      default: begin
        d_bit_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs decode the next state so they
  // line up with the state register and never glitch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      inh_cnt_r  <= '0;
      to_cnt_r   <= '0;
      edge_cnt_r <= 4'd0;
      sh_r       <= 8'h00;
      par_r      <= 1'b0;
      err_flag_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      clk_oe_r   <= 1'b0;
      d_oe_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      inh_cnt_r  <= inh_cnt_nx;
      to_cnt_r   <= to_cnt_nx;
      edge_cnt_r <= edge_cnt_nx;
      sh_r       <= sh_nx;
      par_r      <= par_nx;
      err_flag_r <= err_flag_nx;
      busy_r     <= (state_nx != IDLE);
      done_r     <= (state_nx == FIN);
      err_r      <= (state_nx == FIN) && err_flag_nx;
      clk_oe_r   <= (state_nx == INHIBIT) || (state_nx == REQ);
      d_oe_r     <= (state_nx == REQ) ? 1'b1 :
                    (state_nx == BITS) ? d_bit_nx : 1'b0;
    end
  end

  assign busy       = busy_r;
  assign rx_mask    = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign ps2_clk_oe = clk_oe_r;
  assign ps2_d_oe   = d_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
// Timing parameters are scaled down so a full run stays short.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TO   = 300;
  localparam int HALF = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, err, rx_mask;
  logic       ps2_clk_in, ps2_d_in, ps2_clk_oe, ps2_d_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_d_low = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int bits_cyc = 0;
  int mask_bad = 0;
  logic done_err, done_busy, done_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rx_mask    (rx_mask),
    .ps2_clk_in (ps2_clk_in),
    .ps2_d_in   (ps2_d_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_d_oe   (ps2_d_oe)
  );

  // open-drain wired lines: low if either side pulls
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_d_in   = ~(ps2_d_oe | dev_d_low);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_mask !== busy) mask_bad++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_err  = err;
      done_busy = busy;
      done_oe   = ps2_clk_oe | ps2_d_oe;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request one frame and act as the device for n_edges clock pulses.
  // line[0]=start, line[1..8]=data LSB first, line[9]=parity, line[10]=stop.
  task automatic run_frame(input logic [7:0] b, input bit nack, input int n_edges,
                           input bit inject, output logic [10:0] line);
    int inh;
    tx_data  = b;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    inh = 0;
    while (ps2_clk_oe && !ps2_d_oe && inh < INH + 10) begin
      inh++;
      step();
    end
    check("inhibit_len", inh, INH);
    check("req_drive", 32'({ps2_clk_oe, ps2_d_oe}), 32'd3);
    step();
    bits_cyc = cyc;
    check("bits_entry", 32'({ps2_clk_oe, ps2_d_oe}), 32'd1);
    line = '1;
    for (int e = 1; e <= n_edges; e++) begin
      repeat (HALF) step();
      if (e == 1) line[0] = ps2_d_in;
      dev_clk_low = 1'b1;
      if (inject && e == 4) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (HALF - 1) step();
      end else begin
        repeat (HALF) step();
      end
      if (e <= 10) line[e] = ps2_d_in;
      dev_clk_low = 1'b0;
      if (e == 10 && !nack) dev_d_low = 1'b1;
      if (e == 11) dev_d_low = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0);
    int g;
    g = 0;
    while (done_cnt == d0 && g < TO + 100) begin
      g++;
      step();
    end
    check("done_seen", done_cnt - d0, 1);
  endtask

  // Full 11-edge frame with checks against the model's expected line values.
  task automatic full_frame(input logic [7:0] b, input bit nack, input bit exp_par,
                            input bit exp_err, input bit inject);
    logic [10:0] line;
    int d0;
    d0 = done_cnt;
    run_frame(b, nack, 11, inject, line);
    wait_done(d0);
    check("start_bit", 32'(line[0]), 32'd0);
    check("data_bits", 32'(line[8:1]), 32'(b));
    check("parity_bit", 32'(line[9]), 32'(exp_par));
    check("stop_bit", 32'(line[10]), 32'd1);
    check("done_err", 32'(done_err), 32'(exp_err));
    check("done_busy", 32'(done_busy), 32'd1);
    check("done_lines_released", 32'(done_oe), 32'd0);
    repeat (20) step();
    check("single_done", done_cnt - d0, 1);
    check("idle_after", 32'({busy, ps2_clk_oe, ps2_d_oe}), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         nack;
    bit         exp_par;
    bit         exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [10:0] line;
    logic [7:0]  rb;
    bit          rn;
    int          d0;

    vecs[0] = '{data: 8'hED, nack: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'h07, nack: 1'b0, exp_par: 1'b0, exp_err: 1'b0};
    vecs[2] = '{data: 8'hFF, nack: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 8'h00, nack: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 8'hF4, nack: 1'b1, exp_par: 1'b0, exp_err: 1'b1};

    repeat (3) step();
    check("reset_outputs", 32'({busy, done, err, rx_mask, ps2_clk_oe, ps2_d_oe}), 32'd0);
    rst = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 5; i++) begin
      full_frame(vecs[i].data, vecs[i].nack, vecs[i].exp_par, vecs[i].exp_err, 1'b0);
    end

    // random bytes against the model: parity makes the count of ones odd
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      rn = 1'($urandom_range(0, 1));
      full_frame(rb, rn, ($countones(rb) % 2) == 0, rn, 1'b0);
    end

    // tx_start with 0x55 during edge 4 of an 0xED frame is ignored
    full_frame(8'hED, 1'b0, 1'b1, 1'b0, 1'b1);

    // device never clocks: timeout exactly TO cycles after BITS entry
    d0 = done_cnt;
    run_frame(8'hA5, 1'b0, 0, 1'b0, line);
    wait_done(d0);
    check("timeout_latency", done_cyc - bits_cyc, TO);
    check("timeout_err", 32'(done_err), 32'd1);
    check("timeout_lines_released", 32'(done_oe), 32'd0);
    repeat (5) step();

    // reset after edge 6: everything released on the next edge, no done
    d0 = done_cnt;
    run_frame(8'hED, 1'b0, 6, 1'b0, line);
    check("pre_reset_data", 32'(line[6:1]), 32'(6'b101101));
    rst = 1'b0;
    step();
    check("midframe_reset", 32'({busy, done, err, rx_mask, ps2_clk_oe, ps2_d_oe}), 32'd0);
    rst = 1'b1;
    repeat (20) step();
    check("no_done_on_reset", done_cnt - d0, 0);
    full_frame(8'hF4, 1'b0, 1'b0, 1'b0, 1'b0);

    check("rx_mask_tracks_busy", mask_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
